// File: rtl/fft_consts_pkg.sv
// Constants, sample type and index helpers shared by the FFT core and its RAM-side
// loader/unloader blocks.
package fft_consts;

  localparam int N_LOG2   = 10;
  localparam int DATA_W   = 16;
  localparam int MAX_LOG2 = 16;
  localparam int IDX_W    = 4;

  typedef struct packed {
    logic signed [DATA_W-1:0] r;
    logic signed [DATA_W-1:0] i;
  } complex_t;

  // Reverses the low `width` bits of x; bits at and above `width` come back as zero.
  function automatic logic [MAX_LOG2-1:0] bitrev(input logic [MAX_LOG2-1:0] x, input int width);
    logic [MAX_LOG2-1:0] r;
    r = {MAX_LOG2{1'b0}};
    for (int b = 0; b < MAX_LOG2; b++) begin
      if (b < width) begin
        r[IDX_W'(b)] = x[IDX_W'(width - 1 - b)];
      end else begin
        r[IDX_W'(b)] = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_out_streamer_sync_fifo.sv
// Small synchronous FIFO with registered occupancy and a head-of-queue view,
// shared by the FFT result unloader and input loader.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  localparam int OCC_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [OCC_W-1:0] o_occ
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [OCC_W-1:0] r_occ;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  assign w_pop  = i_pop && (r_occ != {OCC_W{1'b0}});
  assign o_head = r_mem[r_rptr];
  assign o_occ  = r_occ;

  // Storage; cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= {WIDTH{1'b0}};
      end
    end else if (i_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave occupancy unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= {PTR_W{1'b0}};
      r_rptr <= {PTR_W{1'b0}};
      r_occ  <= {OCC_W{1'b0}};
    end else begin
      r_wptr <= i_push ? ptr_inc(r_wptr) : r_wptr;
      r_rptr <= w_pop ? ptr_inc(r_rptr) : r_rptr;
      case ({i_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  sync_fifo_chk #(.OCC_W(OCC_W), .DEPTH(DEPTH)) u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (i_push),
    .i_occ  (r_occ)
  );

endmodule

// Overflow checker: the producer must never push into a full FIFO.
module sync_fifo_chk #(
  parameter int OCC_W = 2,
  parameter int DEPTH = 3
) (
  input logic             clk,
  input logic             rst_n,
  input logic             i_push,
  input logic [OCC_W-1:0] i_occ
);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && (i_occ == OCC_W'(DEPTH))));

endmodule

// File: rtl/fft_out_streamer.sv
// Unloads the FFT result RAM after the core finishes and streams the spectrum out
// in natural frequency order over valid/ready, absorbing RAM latency and backpressure.
module fft_out_streamer
  import fft_consts::complex_t;
  import fft_consts::bitrev;
  import fft_consts::MAX_LOG2;
#(
  parameter int N_LOG2     = fft_consts::N_LOG2,
  parameter int BITREV     = 1,
  parameter int FIFO_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              bank_sel,
  output logic              rd_en,
  output logic              rd_bank,
  output logic [N_LOG2-1:0] rd_addr,
  input  complex_t          rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output complex_t          m_data,
  output logic [N_LOG2-1:0] m_index,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int CPLX_W  = $bits(complex_t);
  localparam int ENTRY_W = N_LOG2 + CPLX_W;
  localparam int OCC_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [N_LOG2-1:0] LAST_IDX = {N_LOG2{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_bank;
  logic                 r_inflight;
  logic                 r_done;
  logic [N_LOG2-1:0]    r_idx;
  logic [N_LOG2-1:0]    r_tag;
  logic                 w_issue;
  logic                 w_start_ok;
  logic                 w_pop;
  logic                 w_last_pop;
  logic [OCC_W-1:0]     w_occ;
  logic [OCC_W:0]       w_outstanding;
  logic [ENTRY_W-1:0]   w_head;
  logic [MAX_LOG2-1:0]  w_rev;
  logic                 w_unused_rev;

  // Occupancy plus the read still in the RAM pipe bounds issue, so the FIFO cannot overflow.
  assign w_outstanding = {1'b0, w_occ} + {{OCC_W{1'b0}}, r_inflight};
  assign w_pop         = m_valid && m_ready;
  assign w_last_pop    = w_pop && m_last;

  // Next-state and read-issue decode.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_start_ok  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_start_ok  = 1'b1;
          w_state_nxt = ST_STREAM;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (w_outstanding < (OCC_W + 1)'(FIFO_DEPTH)) begin
          w_issue     = 1'b1;
          w_state_nxt = (r_idx == LAST_IDX) ? ST_DRAIN : ST_STREAM;
        end else begin
          w_state_nxt = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        if (w_last_pop) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Control registers; the issue counter holds at N-1 rather than wrapping mid-unload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_bank     <= 1'b0;
      r_idx      <= {N_LOG2{1'b0}};
      r_tag      <= {N_LOG2{1'b0}};
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      r_done     <= (r_state == ST_DRAIN) && w_last_pop;
      if (w_start_ok) begin
        r_bank <= bank_sel;
        r_idx  <= {N_LOG2{1'b0}};
      end else if (w_issue) begin
        r_tag <= r_idx;
        r_idx <= (r_idx == LAST_IDX) ? r_idx : r_idx + N_LOG2'(1);
      end
    end
  end

  assign w_rev        = bitrev(MAX_LOG2'(r_idx), N_LOG2);
  assign w_unused_rev = ^w_rev;

  assign rd_en   = w_issue;
  assign rd_bank = r_bank;
  assign rd_addr = (BITREV != 0) ? w_rev[N_LOG2-1:0] : r_idx;

  sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (r_inflight),
    .i_data ({r_tag, rd_data}),
    .i_pop  (w_pop),
    .o_head (w_head),
    .o_occ  (w_occ)
  );

  assign m_valid = (w_occ != {OCC_W{1'b0}});
  assign m_index = w_head[ENTRY_W-1:CPLX_W];
  assign m_data  = complex_t'(w_head[CPLX_W-1:0]);
  assign m_last  = m_valid && (m_index == LAST_IDX);
  assign busy    = (r_state != ST_IDLE);
  assign done    = r_done;

endmodule

// File: tb/tb_fft_out_streamer.sv
// Directed bench: natural-order and bit-reversed instances run side by side on the
// same control stimulus, each fed by its own model of the A/B result RAMs.
module tb_fft_out_streamer;
  import fft_consts::complex_t;

  localparam int N = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic bank_sel = 1'b0;
  logic m_ready = 1'b0;

  logic       rd_en [2];
  logic       rd_bank [2];
  logic [9:0] rd_addr [2];
  complex_t   rd_data [2];
  logic       m_valid [2];
  complex_t   m_data [2];
  logic [9:0] m_index [2];
  logic       m_last [2];
  logic       busy [2];
  logic       done [2];

  logic [31:0] ram_a [N];
  logic [31:0] ram_b [N];

  int n_cmp = 0;
  int n_err = 0;
  int exp_idx [2];
  int acc [2];
  int iss [2];
  logic hold_v [2];
  logic [9:0] hold_idx [2];
  logic [31:0] hold_dat [2];
  logic exp_bank = 1'b0;
  int cyc = 0;
  int e0_cyc = 0;
  bit chk_last_time = 1'b0;
  bit rnd_mode = 1'b0;

  always #5 clk = ~clk;

  fft_out_streamer #(.BITREV(0)) u_nat (
    .clk(clk), .rst_n(rst_n), .start(start), .bank_sel(bank_sel),
    .rd_en(rd_en[0]), .rd_bank(rd_bank[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready), .m_data(m_data[0]), .m_index(m_index[0]),
    .m_last(m_last[0]), .busy(busy[0]), .done(done[0])
  );

  fft_out_streamer #(.BITREV(1)) u_rev (
    .clk(clk), .rst_n(rst_n), .start(start), .bank_sel(bank_sel),
    .rd_en(rd_en[1]), .rd_bank(rd_bank[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready), .m_data(m_data[1]), .m_index(m_index[1]),
    .m_last(m_last[1]), .busy(busy[1]), .done(done[1])
  );

  // One-cycle-latency RAM pair per instance.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rd_en[d]) rd_data[d] <= complex_t'(rd_bank[d] ? ram_b[rd_addr[d]] : ram_a[rd_addr[d]]);
    end
  end

  function automatic logic [9:0] brev10(input logic [9:0] x);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = x[9-i];
    return r;
  endfunction

  // Bank A word k = {r:k, i:-k}; bank B word k = {r:k+0x4000, i:k}.
  function automatic logic [31:0] word(input logic bank, input logic [9:0] a);
    logic [15:0] k;
    k = {6'd0, a};
    return bank ? {k | 16'h4000, k} : {k, 16'd0 - k};
  endfunction

  task automatic chk(input int d, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL dut%0d %s: observed %0h expected %0h", d, tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk(d, {tag, ".rd_en"},   32'(rd_en[d]),   32'd0);
      chk(d, {tag, ".rd_bank"}, 32'(rd_bank[d]), 32'd0);
      chk(d, {tag, ".rd_addr"}, 32'(rd_addr[d]), 32'd0);
      chk(d, {tag, ".m_valid"}, 32'(m_valid[d]), 32'd0);
      chk(d, {tag, ".m_data"},  32'(m_data[d]),  32'd0);
      chk(d, {tag, ".m_index"}, 32'(m_index[d]), 32'd0);
      chk(d, {tag, ".m_last"},  32'(m_last[d]),  32'd0);
      chk(d, {tag, ".busy"},    32'(busy[d]),    32'd0);
      chk(d, {tag, ".done"},    32'(done[d]),    32'd0);
    end
  endtask

  task automatic sb_clear(input logic bank);
    for (int d = 0; d < 2; d++) begin
      exp_idx[d] = 0;
      acc[d] = 0;
      iss[d] = 0;
      hold_v[d] = 1'b0;
    end
    exp_bank = bank;
  endtask

  // Samples both instances at the falling edge, scores any handshake, then advances a cycle.
  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      if (busy[d]) chk(d, "rd_bank", 32'(rd_bank[d]), 32'(exp_bank));
      if (rd_en[d]) iss[d]++;
      chk(d, "outstanding_le_3", 32'(iss[d] - acc[d] <= 3), 32'd1);
      if (hold_v[d]) begin
        chk(d, "hold_valid", 32'(m_valid[d]), 32'd1);
        chk(d, "hold_index", 32'(m_index[d]), 32'(hold_idx[d]));
        chk(d, "hold_data",  32'(m_data[d]),  hold_dat[d]);
      end
      hold_v[d] = 1'b0;
      if (m_valid[d]) begin
        if (m_ready) begin
          chk(d, "index", 32'(m_index[d]), 32'(exp_idx[d]));
          chk(d, "data",  32'(m_data[d]),
              word(exp_bank, (d == 1) ? brev10(10'(exp_idx[d])) : 10'(exp_idx[d])));
          chk(d, "last",  32'(m_last[d]), 32'(exp_idx[d] == N - 1));
          if (chk_last_time && exp_idx[d] == N - 1) chk(d, "last_latency", 32'(cyc - e0_cyc), 32'(N + 1));
          exp_idx[d]++;
          acc[d]++;
        end else begin
          hold_v[d] = 1'b1;
          hold_idx[d] = m_index[d];
          hold_dat[d] = m_data[d];
        end
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_start(input logic bank);
    start = 1'b1;
    bank_sel = bank;
    tick();
    start = 1'b0;
    e0_cyc = cyc;
  endtask

  // Streams until both instances have delivered N beats, then checks the done pulse.
  task automatic run(input string tag, input int budget);
    int t;
    t = 0;
    while ((acc[0] < N || acc[1] < N) && t < budget) begin
      if (rnd_mode) m_ready = ($urandom_range(0, 9) < 3);
      tick();
      t++;
    end
    for (int d = 0; d < 2; d++) begin
      chk(d, {tag, ".beats"}, 32'(acc[d]), 32'(N));
      chk(d, {tag, ".done"},  32'(done[d]), 32'd1);
      chk(d, {tag, ".busy"},  32'(busy[d]), 32'd0);
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      ram_a[k] = word(1'b0, 10'(k));
      ram_b[k] = word(1'b1, 10'(k));
    end
    sb_clear(1'b0);
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Natural order and bit reversal with no backpressure.
    m_ready = 1'b1;
    chk_last_time = 1'b1;
    sb_clear(1'b0);
    do_start(1'b0);
    for (int d = 0; d < 2; d++) begin
      chk(d, "t1.busy_e0",  32'(busy[d]),    32'd1);
      chk(d, "t1.rd_en_e0", 32'(rd_en[d]),   32'd1);
      chk(d, "t1.addr0",    32'(rd_addr[d]), 32'd0);
    end
    tick();
    chk(0, "t1.valid_e1", 32'(m_valid[0]), 32'd0);
    chk(1, "t1.valid_e1", 32'(m_valid[1]), 32'd0);
    chk(0, "t1.addr1", 32'(rd_addr[0]), 32'd1);
    chk(1, "t2.addr1", 32'(rd_addr[1]), 32'd512);
    tick();
    chk(0, "t1.valid_e2", 32'(m_valid[0]), 32'd1);
    chk(1, "t1.valid_e2", 32'(m_valid[1]), 32'd1);
    tick();
    chk(0, "t1.addr3", 32'(rd_addr[0]), 32'd3);
    chk(1, "t2.addr3", 32'(rd_addr[1]), 32'd768);
    run("t1", 1200);
    tick();
    chk(0, "t1.done_single", 32'(done[0]), 32'd0);
    chk(1, "t1.done_single", 32'(done[1]), 32'd0);
    chk_last_time = 1'b0;

    // Backpressure: ready low stalls issue at FIFO depth, then 30% random ready.
    sb_clear(1'b0);
    m_ready = 1'b0;
    do_start(1'b0);
    repeat (20) tick();
    for (int d = 0; d < 2; d++) begin
      chk(d, "t3.stall_reads", 32'(iss[d]), 32'd3);
      chk(d, "t3.stall_rd_en", 32'(rd_en[d]), 32'd0);
    end
    rnd_mode = 1'b1;
    run("t3", 9000);
    rnd_mode = 1'b0;
    m_ready = 1'b1;
    tick();

    // Bank B with a stray start mid-stream.
    sb_clear(1'b1);
    do_start(1'b1);
    chk(0, "t4.bank", 32'(rd_bank[0]), 32'd1);
    repeat (50) tick();
    start = 1'b1;
    bank_sel = 1'b0;
    tick();
    start = 1'b0;
    run("t4", 1200);
    tick();

    // Reset mid-unload after beat 100, then a fresh unload.
    sb_clear(1'b0);
    do_start(1'b0);
    for (int t = 0; t < 400 && acc[0] <= 100; t++) tick();
    chk(0, "t5.reached_beat_100", 32'(acc[0] > 100), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_zero("t5.async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sb_clear(1'b0);
    do_start(1'b0);
    run("t5", 1200);

    // Back-to-back: start issued in the done cycle.
    sb_clear(1'b1);
    do_start(1'b1);
    for (int d = 0; d < 2; d++) begin
      chk(d, "t6.rd_en", 32'(rd_en[d]), 32'd1);
      chk(d, "t6.busy",  32'(busy[d]),  32'd1);
      chk(d, "t6.addr0", 32'(rd_addr[d]), 32'd0);
      chk(d, "t6.bank",  32'(rd_bank[d]), 32'd1);
    end
    run("t6", 1200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
